// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional/sticky parity, one stop bit.
// Frames are presented with a one-clk push together with parity, framing and break flags.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [3:0]  count_q, count_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        armed_q, armed_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  wls_q, wls_d;
    logic        pen_q, pen_d, eps_q, eps_d, sticky_q, sticky_d;
    logic        par_bit_q, par_bit_d;
    logic [7:0]  dout_q, dout_d;
    logic        pe_q, pe_d, fe_q, fe_d, bi_q, bi_d, push_q, push_d;

    logic        start_seen, sample_now, last_bit, exp_par;

    assign start_seen = !rx_s_q && armed_q;
    assign sample_now = (count_q == 4'd0);
    assign last_bit   = (bitcnt_q == ({1'b0, wls_q} + 3'd4));
    // Upper shift bits are cleared at frame start, so XOR over all 8 covers only received data.
    assign exp_par    = sticky_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            bitcnt_q  <= 3'd0;
            armed_q   <= 1'b1;
            shift_q   <= 8'h00;
            wls_q     <= 2'b00;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sticky_q  <= 1'b0;
            par_bit_q <= 1'b0;
            dout_q    <= 8'h00;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bitcnt_q  <= bitcnt_d;
            armed_q   <= armed_d;
            shift_q   <= shift_d;
            wls_q     <= wls_d;
            pen_q     <= pen_d;
            eps_q     <= eps_d;
            sticky_q  <= sticky_d;
            par_bit_q <= par_bit_d;
            dout_q    <= dout_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
            push_q    <= push_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (baud_pulse) begin
            case (state_q)
                IDLE:    if (start_seen) state_d = START;
                START:   if (sample_now) state_d = rx_s_q ? IDLE : DATA;
                DATA:    if (sample_now && last_bit) state_d = pen_q ? PARITY : STOP;
                PARITY:  if (sample_now) state_d = STOP;
                STOP:    if (sample_now) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        count_d   = count_q;
        bitcnt_d  = bitcnt_q;
        armed_d   = armed_q;
        shift_d   = shift_q;
        wls_d     = wls_q;
        pen_d     = pen_q;
        eps_d     = eps_q;
        sticky_d  = sticky_q;
        par_bit_d = par_bit_q;
        dout_d    = dout_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;
        push_d    = 1'b0;
        if (baud_pulse) begin
            if (rx_s_q) armed_d = 1'b1;
            if (state_q != IDLE && !sample_now) count_d = count_q - 4'd1;
            case (state_q)
                IDLE: begin
                    if (start_seen) begin
                        count_d  = 4'd7;
                        shift_d  = 8'h00;
                        wls_d    = wls;
                        pen_d    = pen;
                        eps_d    = eps;
                        sticky_d = sticky_parity;
                    end
                end
                START: begin
                    if (sample_now && !rx_s_q) begin
                        count_d  = 4'd15;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    if (sample_now) begin
                        shift_d[bitcnt_q] = rx_s_q;
                        bitcnt_d          = bitcnt_q + 3'd1;
                        count_d           = 4'd15;
                    end
                end
                PARITY: begin
                    if (sample_now) begin
                        par_bit_d = rx_s_q;
                        count_d   = 4'd15;
                    end
                end
                STOP: begin
                    if (sample_now) begin
                        dout_d = shift_q;
                        pe_d   = pen_q && (par_bit_q != exp_par);
                        fe_d   = ~rx_s_q;
                        bi_d   = (shift_q == 8'h00) && !rx_s_q && (!pen_q || !par_bit_q);
                        push_d = 1'b1;
                        // A zero stop bit disarms until the line is seen idle again.
                        if (!rx_s_q) armed_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign push = push_q;
    assign dout = dout_q;
    assign pe   = pe_q;
    assign fe   = fe_q;
    assign bi   = bi_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames
// compared against a frame-level reference model and expectation queue.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;  // 16 baud pulses, one every 4 clk

    logic       clk = 1'b0;
    logic       rst, baud_pulse, rx, pen, eps, sticky_parity;
    logic [1:0] wls;
    logic       push, pe, fe, bi;
    logic [7:0] dout;

    typedef struct {
        logic [7:0] dout;
        logic       pe, fe, bi;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   push_cnt = 0;
    int   div = 0;

    uart_rx dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
        .pen(pen), .eps(eps), .sticky_parity(sticky_parity), .wls(wls),
        .push(push), .dout(dout), .pe(pe), .fe(fe), .bi(bi)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = (div + 1) % 4;
        baud_pulse = (div == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every push must match the oldest expected frame.
    always @(negedge clk) begin
        if (push === 1'b1) begin
            exp_t e;
            push_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_push", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout", dout, e.dout);
                check("pe", pe, e.pe);
                check("fe", fe, e.fe);
                check("bi", bi, e.bi);
            end
        end
    end

    // Parity bit the transmitter should send, from the count of ones.
    function automatic logic ref_parity(input logic [7:0] d, input logic e, input logic s);
        int ones = $countones(d);
        if (s) return !e;
        if (e) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [1:0] w, input logic p,
                              input logic e, input logic s, input logic par_bit,
                              input logic stop_b, input int idle_bits);
        int   n = 5 + int'(w);
        logic [7:0] d;
        exp_t x;
        d = data & 8'((1 << n) - 1);
        x.dout = d;
        x.pe   = p && (par_bit != ref_parity(d, e, s));
        x.fe   = !stop_b;
        x.bi   = (d == 8'h00) && !stop_b && (!p || !par_bit);
        exp_q.push_back(x);
        wls = w; pen = p; eps = e; sticky_parity = s;
        drive_bit(1'b0);
        // Scramble configuration; the frame in flight must ignore it.
        wls = 2'($urandom); pen = 1'($urandom); eps = 1'($urandom); sticky_parity = 1'($urandom);
        for (int i = 0; i < n; i++) drive_bit(d[i]);
        if (p) drive_bit(par_bit);
        drive_bit(stop_b);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
        check("push_seen", exp_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt0;
        rst = 1'b1; rx = 1'b1; pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; wls = 2'b11;
        baud_pulse = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_push", push, 0);
        check("rst_dout", dout, 0);
        check("rst_flags", {pe, fe, bi}, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // 8-bit frame, no parity.
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        // 5-bit even parity with wrong parity bit.
        send_frame(8'h13, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        // Sticky parity, 7 bits: expected parity bit is 1.
        send_frame(8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        send_frame(8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1);

        // False start: short low pulse must not produce a frame.
        cnt0 = push_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("false_start_push", push_cnt, cnt0);
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Held break: exactly one push, then silence until the line idles.
        cnt0 = push_cnt;
        wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
        exp_q.push_back('{dout: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1});
        rx = 1'b0;
        repeat (3 * 12 * BIT_CLKS) @(negedge clk);
        check("break_push_count", push_cnt, cnt0 + 1);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break_no_repush", push_cnt, cnt0 + 1);
        send_frame(8'h6E, 2'b11, 1'b1, 1'b1, 1'b0, ref_parity(8'h6E, 1'b1, 1'b0), 1'b1, 1);

        // Reset during data bit 3 of 0xFF.
        cnt0 = push_cnt;
        wls = 2'b11; pen = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        check("rst_abort_push", push_cnt, cnt0);
        check("rst_abort_dout", dout, 0);
        check("rst_abort_flags", {pe, fe, bi}, 0);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Randomized frames.
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            logic [1:0] w;
            logic p, e, s, pb, sb;
            d  = 8'($urandom);
            w  = 2'($urandom);
            p  = 1'($urandom);
            e  = 1'($urandom);
            s  = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            pb = ref_parity(d & 8'((1 << (5 + int'(w))) - 1), e, s);
            if ($urandom_range(0, 3) == 0) pb = !pb;
            sb = ($urandom_range(0, 5) != 0);
            send_frame(d, w, p, e, s, pb, sb, int'($urandom_range(1, 2)));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 No parameters; oversampling fixed at 16 baud_pulse per bit.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 baud_pulse  in  1  16x bit-rate enable, one clk wide; all counters advance only in cycles where it is high.
REQ-005 rx  in  1  serial line, idle high, LSB first; asynchronous to clk.
REQ-006 pen  in  1  parity enable.
REQ-007 eps  in  1  even parity select (1 = even, 0 = odd).
REQ-008 sticky_parity  in  1  forces parity: eps=0 -> expect 1, eps=1 -> expect 0.
REQ-009 wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-010 push  out  1  one-clk pulse; a received frame is presented on dout/pe/fe/bi.
REQ-011 dout  out  8  received data, right-aligned; unused upper bits 0.
REQ-012 pe  out  1  parity error for the frame presented with push.
REQ-013 fe  out  1  framing error (stop bit sampled 0).
REQ-014 bi  out  1  break indication (all data, parity if enabled, and stop sampled 0).

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (clocked every clk, reset to 1); all sampling uses the synchronized value rx_s.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions only in baud_pulse cycles (except reset).
REQ-017 IDLE: on baud_pulse with rx_s=0 and armed=1 -> START, count=7; wls, pen, eps, sticky_parity latched at this point and held for the frame.
REQ-018 START: count decrements per baud_pulse; at count=0 rx_s=0 -> DATA, count=15, bitcnt=0; rx_s=1 -> IDLE (false start, no push).
REQ-019 DATA: at count=0 sample rx_s into bit position bitcnt of shift register, count=15, bitcnt+1; after bit (5+wls_latched) -> PARITY if pen else STOP.
REQ-020 PARITY: at count=0 sample rx_s as parity bit, count=15 -> STOP.
REQ-021 Expected parity: {sticky,eps}=00 -> ~^data, 01 -> ^data, 10 -> 1, 11 -> 0; XOR over received data bits only; pe=1 when sampled parity != expected; pe=0 when pen=0.
REQ-022 STOP: at count=0 sample stop bit; fe=~rx_s; bi=1 when data==0, stop==0, and (pen==0 or parity==0); -> IDLE.
REQ-023 push SHALL be high for exactly the one clk cycle following the STOP sampling edge; dout/pe/fe/bi update on that same edge and hold until the next push.
REQ-024 Only one stop bit SHALL be checked regardless of transmitter stop-bit setting.
REQ-025 armed SHALL clear when a frame ends with fe=1 and set again once rx_s=1 is seen in a baud_pulse cycle; prevents a held-low break retriggering frames.
REQ-026 Input configuration changes mid-frame SHALL NOT affect the frame in progress.
REQ-027 Sample point SHALL be mid-bit: 8 baud_pulses after start-edge detect, then every 16.

Reset
REQ-028 On rst: state=IDLE, count=0, bitcnt=0, armed=1, sync flops=1, shift register=0, dout=0, push=0, pe=0, fe=0, bi=0.
REQ-029 Reset mid-frame SHALL abort the frame with no push; reception resumes on the next valid start after rst deasserts.

Verification
REQ-030 wls=11, pen=0, frame 0xA5 with valid stop -> one push, dout=0xA5, pe=fe=bi=0.
REQ-031 wls=00, pen=1, eps=1, data 0x13 with parity bit 0 -> push, dout=0x13, pe=1, fe=0.
REQ-032 pen=1, sticky_parity=1, eps=0, wls=10, data 0x55, parity 1 -> pe=0; repeat with parity 0 -> pe=1.
REQ-033 rx low for 4 baud_pulses then high -> no push, FSM back in IDLE before the next start edge.
REQ-034 wls=11, pen=1, rx held low 3 frame times -> exactly one push with dout=0x00, fe=1, bi=1; no further push until rx returns high and a new start is sent.
REQ-035 rst asserted during data bit 3 of a 0xFF frame -> push never asserts, all outputs 0; next 0x3C frame received correctly.
